// File: rtl/pw_lock_pkg.sv
// Shared state encoding and default parameter values for the password lock.
`timescale 1ns/1ps
package pw_lock_pkg;

  localparam int DEF_DIGITS         = 4;
  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_SET_NEW  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level input is seen high.
`timescale 1ns/1ps
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/param_password_lock.sv
// Parameterised digit-entry password lock with change mode and timed lockout.
// state       | meaning
// ST_LOCKED   | collecting digits, compare on the last one
// ST_UNLOCKED | open; change -> set new password, set -> relock
// ST_SET_NEW  | collecting the new password, set commits, change aborts
// ST_LOCKOUT  | too many failures; all inputs ignored until timer expires
`timescale 1ns/1ps
module param_password_lock
  import pw_lock_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PW = '1,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DIGIT_W-1:0]                hex_in,
  input  logic                              enter,
  input  logic                              set,
  input  logic                              change,
  output logic [DIGITS*DIGIT_W-1:0]         current_password,
  output logic [1:0]                        state,
  output logic                              local_reset,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
  output logic [$clog2(DIGITS+1)-1:0]       digit_count
);

  localparam int PW_W   = DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

  logic ent, st, chg;

  edge_pulse u_enter  (.clk(clk), .reset(reset), .level(enter),  .pulse(ent));
  edge_pulse u_set    (.clk(clk), .reset(reset), .level(set),    .pulse(st));
  edge_pulse u_change (.clk(clk), .reset(reset), .level(change), .pulse(chg));

  lock_state_e          state_q, state_d;
  logic [PW_W-1:0]      buf_q, buf_d, pw_q, pw_d, buf_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 lr_q, clear;

  assign buf_shift = (buf_q << DIGIT_W) | PW_W'(hex_in);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    pw_d    = pw_q;
    clear   = 1'b0;
    case (state_q)
      ST_LOCKOUT: begin
        if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          fail_d  = '0;
          clear   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (chg) begin
          state_d = ST_SET_NEW;
          clear   = 1'b1;
        end else if (st) begin
          state_d = ST_LOCKED;
          clear   = 1'b1;
        end
      end
      ST_SET_NEW: begin
        if (chg) begin
          state_d = ST_UNLOCKED;
          clear   = 1'b1;
        end else if (st) begin
          // A partial password is not committed; the buffer is kept as-is.
          if (cnt_q == CNT_W'(DIGITS)) begin
            pw_d    = buf_q;
            state_d = ST_LOCKED;
            clear   = 1'b1;
          end
        end else if (ent && (cnt_q < CNT_W'(DIGITS))) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // change/set have no effect here but still outrank enter.
        if (ent && !chg && !st) begin
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            clear = 1'b1;
            if (buf_shift == pw_q) begin
              state_d = ST_UNLOCKED;
              fail_d  = '0;
            end else if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
              state_d = ST_LOCKOUT;
              fail_d  = FAIL_W'(MAX_FAILS);
              tmr_d   = TMR_W'(LOCKOUT_CYCLES);
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      pw_q    <= DEFAULT_PW;
      lr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      pw_q    <= pw_d;
      lr_q    <= clear;
    end
  end

  assign current_password = pw_q;
  assign state            = state_q;
  assign local_reset      = lr_q;
  assign fail_count       = fail_q;
  assign digit_count      = cnt_q;

endmodule

// File: tb/tb_param_password_lock.sv
// Directed bench for param_password_lock at default size and with 6 digits.
`timescale 1ns/1ps
module tb_param_password_lock;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hex;
  logic        enter, set, change;
  logic [15:0] pw;
  logic [1:0]  state;
  logic        lr;
  logic [1:0]  fail;
  logic [2:0]  digit;

  logic [3:0]  hex2;
  logic        enter2, set2, change2;
  logic [23:0] pw2;
  logic [1:0]  state2;
  logic        lr2;
  logic [1:0]  fail2;
  logic [2:0]  digit2;

  int checks = 0;
  int errors = 0;
  logic last_lr;
  int cnt;

  always #5 clk = ~clk;

  param_password_lock dut (
    .clk(clk), .reset(rst), .hex_in(hex), .enter(enter), .set(set), .change(change),
    .current_password(pw), .state(state), .local_reset(lr), .fail_count(fail),
    .digit_count(digit)
  );

  param_password_lock #(.DIGITS(6), .DIGIT_W(4)) dut6 (
    .clk(clk), .reset(rst), .hex_in(hex2), .enter(enter2), .set(set2), .change(change2),
    .current_password(pw2), .state(state2), .local_reset(lr2), .fail_count(fail2),
    .digit_count(digit2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    hex = d; enter = 1'b1; tick(); last_lr = lr; enter = 1'b0; tick();
  endtask

  task automatic press2(input logic [3:0] d);
    hex2 = d; enter2 = 1'b1; tick(); enter2 = 1'b0; tick();
  endtask

  task automatic pulse_change();
    change = 1'b1; tick(); last_lr = lr; change = 1'b0; tick();
  endtask

  task automatic pulse_set();
    set = 1'b1; tick(); last_lr = lr; set = 1'b0; tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pw"},    32'(pw),    32'hFFFF);
    chk({tag, "_digit"}, 32'(digit), 32'd0);
    chk({tag, "_fail"},  32'(fail),  32'd0);
    chk({tag, "_lr"},    32'(lr),    32'd1);
  endtask

  initial begin
    rst = 1'b0; hex = '0; enter = 0; set = 0; change = 0;
    hex2 = '0; enter2 = 0; set2 = 0; change2 = 0;
    tick(); tick();
    chk_reset_vals("por");
    chk("por_state6", 32'(state2), 32'd0);
    chk("por_pw6",    32'(pw2),    32'hFFFFFF);
    rst = 1'b1; tick();
    chk("por_lr_low", 32'(lr), 32'd0);

    // unlock with the default password
    press(4'hF);
    chk("t1_digit1", 32'(digit), 32'd1);
    repeat (3) press(4'hF);
    chk("t1_state", 32'(state), 32'd1);
    chk("t1_fail",  32'(fail),  32'd0);
    chk("t1_lr",    32'(last_lr), 32'd1);
    chk("t1_digit", 32'(digit), 32'd0);

    // change password to AAAA
    pulse_change();
    chk("t2_state_set", 32'(state), 32'd2);
    repeat (4) press(4'hA);
    chk("t2_digit4", 32'(digit), 32'd4);
    press(4'hA);
    chk("t2_digit_sat", 32'(digit), 32'd4);
    pulse_set();
    chk("t2_pw",    32'(pw),    32'hAAAA);
    chk("t2_state", 32'(state), 32'd0);
    chk("t2_lr",    32'(last_lr), 32'd1);
    repeat (4) press(4'hA);
    chk("t2_unlock", 32'(state), 32'd1);
    pulse_set();
    chk("t2_relock", 32'(state), 32'd0);

    // three wrong entries -> lockout
    rst = 1'b0; tick(); rst = 1'b1; tick();
    for (int a = 0; a < 3; a++) begin
      for (int d = 0; d < 4; d++) begin
        if (a == 2 && d == 3) begin
          hex = 4'h0; enter = 1'b1; tick();
        end else begin
          press(4'h0);
        end
      end
      if (a == 0) chk("t3_fail1", 32'(fail), 32'd1);
      if (a == 1) chk("t3_fail2", 32'(fail), 32'd2);
    end
    chk("t3_lockout", 32'(state), 32'd3);
    chk("t3_fail3",   32'(fail),  32'd3);
    cnt = 1;
    enter = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 3) enter = 1'b1;
      if (i == 5) enter = 1'b0;
      tick();
      if (state != 2'd3) break;
      cnt++;
      if (i == 6) chk("t3_ignored", 32'(digit), 32'd0);
    end
    chk("t3_cycles", 32'(cnt),   32'd16);
    chk("t3_exit",   32'(state), 32'd0);
    chk("t3_clr",    32'(fail),  32'd0);
    chk("t3_digit",  32'(digit), 32'd0);

    // abort and partial commit
    repeat (4) press(4'hF);
    chk("t4_unlock", 32'(state), 32'd1);
    pulse_change();
    press(4'h2); press(4'h3);
    chk("t4_digit2", 32'(digit), 32'd2);
    pulse_change();
    chk("t4_abort", 32'(state), 32'd1);
    chk("t4_pw",    32'(pw),    32'hFFFF);
    pulse_change();
    repeat (3) press(4'h1);
    pulse_set();
    chk("t4_nocommit_state", 32'(state), 32'd2);
    chk("t4_nocommit_pw",    32'(pw),    32'hFFFF);
    chk("t4_nocommit_digit", 32'(digit), 32'd3);
    pulse_change();
    chk("t4_back", 32'(state), 32'd1);

    // held enter and simultaneous change+set
    pulse_change();
    hex = 4'h7; enter = 1'b1;
    repeat (10) tick();
    enter = 1'b0; tick();
    chk("t5_held", 32'(digit), 32'd1);
    pulse_change();
    chk("t5_unl", 32'(state), 32'd1);
    change = 1'b1; set = 1'b1; tick(); change = 1'b0; set = 1'b0; tick();
    chk("t5_prio", 32'(state), 32'd2);

    // reset mid-lockout and mid-SET_NEW
    repeat (4) press(4'h5);
    pulse_set();
    chk("t6_pw5555", 32'(pw), 32'h5555);
    repeat (12) press(4'h0);
    chk("t6_lockout", 32'(state), 32'd3);
    repeat (3) tick();
    rst = 1'b0; tick();
    chk_reset_vals("t6_rst_lock");
    rst = 1'b1; tick();
    chk("t6_lr_low", 32'(lr), 32'd0);
    repeat (4) press(4'hF);
    pulse_change();
    press(4'h1); press(4'h2);
    chk("t6_mid_digit", 32'(digit), 32'd2);
    rst = 1'b0; tick();
    chk_reset_vals("t6_rst_set");
    rst = 1'b1; tick();

    // six-digit instance
    repeat (6) press2(4'h0);
    chk("t7_fail",  32'(fail2),  32'd1);
    chk("t7_state", 32'(state2), 32'd0);
    repeat (4) press2(4'hF);
    chk("t7_digit4", 32'(digit2), 32'd4);
    chk("t7_still",  32'(state2), 32'd0);
    repeat (2) press2(4'hF);
    chk("t7_unlock", 32'(state2), 32'd1);
    chk("t7_fail0",  32'(fail2),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
